// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM states,
// pixel formats and default frame geometry.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_VBLANK = 3'd2,
        ST_BYTE1  = 3'd3,
        ST_BYTE2  = 3'd4
    } state_t;

    localparam int FMT_RGB444 = 12;
    localparam int FMT_RGB332 = 8;
    localparam int FMT_RGB111 = 3;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;

    function automatic bit fmt_legal(input int dw);
        return (dw == FMT_RGB444) || (dw == FMT_RGB332) || (dw == FMT_RGB111);
    endfunction

endpackage

// File: rtl/cam_px_capture_rgb565_pack.sv
// Combinational RGB565 byte-pair to RGB444/332/111 pixel packer.
// b1 is the first (high) byte on the wire, b2 the second.
module rgb565_pack
    import cam_pkg::*;
#(
    parameter int DW = FMT_RGB444
) (
    input  logic [7:0]    b1,
    input  logic [7:0]    b2,
    output logic [DW-1:0] px
);

    // Each format keeps only the top bits of R, G and B.
    generate
        if (DW == FMT_RGB444) begin : g_444
            assign px = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
        end else if (DW == FMT_RGB332) begin : g_332
            assign px = {b1[7:5], b1[2:0], b2[4:3]};
        end else if (DW == FMT_RGB111) begin : g_111
            assign px = {b1[7], b1[2], b2[4]};
        end else begin : g_bad
            $error("rgb565_pack: DW must be 12, 8 or 3");
            assign px = '0;
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{b1, b2};

endmodule

// File: rtl/cam_px_capture.sv
// OV7670 byte-stream capture: pairs bytes into pixels and drives the
// frame-buffer write port, with frame-done and overrun reporting.
module cam_px_capture
    import cam_pkg::*;
#(
    parameter int AW   = 15,
    parameter int DW   = FMT_RGB444,
    parameter int NPIX = IMG_W * IMG_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_en,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          overrun
);

    generate
        if (NPIX < 1 || NPIX > (2 ** AW)) begin : g_bad_npix
            $error("cam_px_capture: NPIX must be in 1..2**AW");
        end
    endgenerate

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t        state_q, state_d;
    logic [7:0]    byte_hi_q, byte_hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          full_q, full_d;
    logic [DW-1:0] pix;

    rgb565_pack #(.DW(DW)) u_pack (
        .b1 (byte_hi_q),
        .b2 (cam_px_data),
        .px (pix)
    );

    always_comb begin
        state_d   = state_q;
        byte_hi_d = byte_hi_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        ovr_d     = ovr_q;
        full_d    = full_q;

        // Address advances after the strobe; the last slot saturates.
        if (wr_q) begin
            if (addr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (init_en) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (cam_vsync) state_d = ST_VBLANK;
            end
            ST_VBLANK: begin
                if (!cam_vsync) begin
                    addr_d  = '0;
                    ovr_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = ST_BYTE1;
                end
            end
            ST_BYTE1: begin
                if (cam_vsync) begin
                    done_d  = 1'b1;
                    state_d = ST_VBLANK;
                end else if (cam_href) begin
                    byte_hi_d = cam_px_data;
                    state_d   = ST_BYTE2;
                end
            end
            ST_BYTE2: begin
                if (cam_vsync) begin
                    done_d  = 1'b1;
                    state_d = ST_VBLANK;
                end else begin
                    state_d = ST_BYTE1;
                    if (cam_href) begin
                        if (full_q) begin
                            ovr_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = pix;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            byte_hi_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_hi_q <= byte_hi_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            full_q    <= full_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign frame_done  = done_q;
    assign overrun     = ovr_q;

endmodule
